// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Holds the IF/ID bundle layout and the bubble helper.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR =
    32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT =
    32'h0000_0000;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  // A bubble keeps the PC fields so decode still sees a stable address.
  function automatic if_id_t if_id_bubble(
    input if_id_t cur
  );
    if_id_t b;
    b       = cur;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch and imem.
// Read data returns one cycle after the address.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned W = XLEN
) ();

  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush loads a bubble and beats hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t r_q;
  if_id_t r_d;

  always_comb begin
    r_d = r_q;
    if (flush) begin
      r_d = if_id_bubble(r_q);
    end else if (!hold) begin
      r_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= IF_ID_RESET;
    end else begin
      r_q <= r_d;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one in-flight imem read,
// and the IF/ID register; honours stall and redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
    RESET_VECTOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] branch_target,
  fetch_unit_if.master          imem,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] pc_f_q;
  logic [DATA_WIDTH-1:0] pc_f_d;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] req_pc_d;
  logic                  req_v_q;
  logic                  req_v_d;
  logic                  misalign_q;
  logic                  misalign_d;
  logic [DATA_WIDTH-1:0] tgt;
  logic                  flush;
  if_id_t                if_id_in;
  if_id_t                if_id_out;

  assign tgt = {branch_target[DATA_WIDTH-1:2], 2'b00};

  // Stalls re-present the in-flight address so the
  // returned word still matches it at release.
  always_comb begin
    imem.imem_addr = pc_f_q;
    if (rst) begin
      imem.imem_addr = RESET_VECTOR;
    end else if (pc_src) begin
      imem.imem_addr = tgt;
    end else if (stall) begin
      imem.imem_addr = req_pc_q;
    end
  end

  always_comb begin
    pc_f_d     = pc_f_q;
    req_pc_d   = req_pc_q;
    req_v_d    = req_v_q;
    misalign_d = 1'b0;
    if (pc_src) begin
      pc_f_d     = tgt + PC_STEP;
      req_pc_d   = tgt;
      req_v_d    = 1'b1;
      misalign_d = |branch_target[1:0];
    end else if (!stall) begin
      pc_f_d   = pc_f_q + PC_STEP;
      req_pc_d = pc_f_q;
      req_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q     <= RESET_VECTOR;
      req_pc_q   <= '0;
      req_v_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      req_pc_q   <= req_pc_d;
      req_v_q    <= req_v_d;
      misalign_q <= misalign_d;
    end
  end

  assign if_id_in = '{
    instr:    imem.imem_rdata,
    pc:       req_pc_q,
    pc_plus4: req_pc_q + PC_STEP,
    valid:    1'b1
  };

  // Redirect squashes wrong path; no read in flight means a bubble.
  assign flush = pc_src | (~stall & ~req_v_q);

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (flush),
    .din   (if_id_in),
    .dout  (if_id_out)
  );

  assign instr_d    = if_id_out.instr;
  assign pc_d       = if_id_out.pc;
  assign pc_plus4_d = if_id_out.pc_plus4;
  assign valid_d    = if_id_out.valid;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an expected-PC scoreboard.
// imem returns each word equal to its own address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  fetch_unit_if #(.W(32)) imem ();

  fetch_unit #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem          (imem),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc_plus4_d    (pc_plus4_d),
    .valid_d       (valid_d),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem.imem_rdata <= imem.imem_addr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic s,
                        input logic p,
                        input logic [31:0] t);
    rst = r;
    stall = s;
    pc_src = p;
    branch_target = t;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra"}, {31'b0, valid_d}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {31'b0, valid_d}, 32'd1);
      chk({tag, "_pc"}, pc_d, e);
      chk({tag, "_instr"}, instr_d, e);
      chk({tag, "_pc4"}, pc_plus4_d, e + 32'd4);
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    cyc();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, NOP_INSTR);
    chk("rst_pc", pc_d, 32'h0);
    chk("rst_pc4", pc_plus4_d, 32'h0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);

    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    chk("boot_addr", imem.imem_addr, 32'h0);
    cyc();
    chk("boot_bubble", {31'b0, valid_d}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    cyc(); pop_chk("run0");
    cyc(); pop_chk("run4");
    cyc(); pop_chk("run8");
    chk("run_mis", {31'b0, misalign_o}, 32'd0);

    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_addr", imem.imem_addr, 32'hC);
      cyc();
      chk("stall_pc", pc_d, 32'h8);
      chk("stall_instr", instr_d, 32'h8);
      chk("stall_valid", {31'b0, valid_d}, 32'd1);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(); pop_chk("relC");
    cyc(); pop_chk("rel10");

    set_in(1'b0, 1'b0, 1'b1, 32'h100);
    chk("br_addr", imem.imem_addr, 32'h100);
    cyc();
    chk("br_valid", {31'b0, valid_d}, 32'd0);
    chk("br_instr", instr_d, NOP_INSTR);
    chk("br_pc_keep", pc_d, 32'h10);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    cyc(); pop_chk("br100");
    cyc(); pop_chk("br104");

    set_in(1'b0, 1'b1, 1'b1, 32'h40);
    chk("brst_addr", imem.imem_addr, 32'h40);
    cyc();
    chk("brst_valid", {31'b0, valid_d}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h40);
    cyc(); pop_chk("brst40");

    set_in(1'b0, 1'b0, 1'b1, 32'h203);
    chk("mis_addr", imem.imem_addr, 32'h200);
    cyc();
    chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
    chk("mis_valid", {31'b0, valid_d}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h200);
    cyc();
    chk("mis_clear", {31'b0, misalign_o}, 32'd0);
    pop_chk("mis200");

    set_in(1'b0, 1'b0, 1'b1, 32'h300);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 32'h500);
    cyc();
    chk("b2b_valid", {31'b0, valid_d}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h504);
    cyc(); pop_chk("b2b500");
    cyc(); pop_chk("b2b504");

    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_valid", {31'b0, valid_d}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cyc(); pop_chk("wrapFC");
    cyc(); pop_chk("wrap0");

    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    chk("st2_addr", imem.imem_addr, 32'h4);
    cyc();
    chk("st2_pc", pc_d, 32'h0);
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rstst_addr", imem.imem_addr, 32'h0);
    cyc();
    chk("rstst_valid", {31'b0, valid_d}, 32'd0);
    chk("rstst_instr", instr_d, NOP_INSTR);
    chk("rstst_pc", pc_d, 32'h0);
    chk("rstst_q", exp_q.size(), 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("rec_bubble", {31'b0, valid_d}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cyc(); pop_chk("rec0");
    cyc(); pop_chk("rec4");
    chk("end_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of branch_control and consumes its pc_src redirect.
- Owns the fetch PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Tracks the one in-flight read and registers the IF/ID pipeline outputs (instruction, PC, PC+4, valid) for decode.
- Handles hazard-unit stalls, taken-branch/jump redirects and misaligned targets.

Parameters:
- DATA_WIDTH, 32, width of PC, target and instruction words.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC, in-flight request and IF/ID.
- pc_src  in  1  redirect request from branch_control (1 = take branch_target).
- branch_target  in  DATA_WIDTH  redirect address computed in EX.
- imem_addr  out  DATA_WIDTH  instruction memory read address; combinational.
- imem_rdata  in  DATA_WIDTH  read data for the address presented on the previous cycle.
- instr_d  out  DATA_WIDTH  IF/ID instruction.
- pc_d  out  DATA_WIDTH  IF/ID PC.
- pc_plus4_d  out  DATA_WIDTH  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  1-cycle pulse: redirect target had [1:0] != 0.

Behaviour:
- State registers:
  - pc_f: next address to issue.
  - pc_q: address of the in-flight read.
  - req_v: in-flight read is valid.
  - IF/ID registers.
- Event priority: rst > pc_src > stall > normal advance.
- Reset (rst=1 at edge):
  - pc_f=RESET_VECTOR, pc_q=0, req_v=0.
  - instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=0, valid_d=0, misalign_o=0.
  - While rst=1, imem_addr=RESET_VECTOR.
  - A reset asserted mid-stall or mid-redirect discards all in-flight state.
- imem_addr (combinational):
  - pc_src=1: tgt = {branch_target[W-1:2], 2'b00}.
  - else stall=1: pc_q.
  - else: pc_f.
  - Re-issuing pc_q during a stall keeps imem_rdata consistent with pc_q on the cycle the stall releases.
- Normal advance (rst=0, pc_src=0, stall=0):
  - pc_q<=pc_f, req_v<=1, pc_f<=pc_f+4.
  - If req_v: instr_d<=imem_rdata, pc_d<=pc_q, pc_plus4_d<=pc_q+4, valid_d<=1.
  - Else: bubble (instr_d=NOP, valid_d=0, pc_d/pc_plus4_d unchanged).
- Stall (pc_src=0):
  - All registers hold, including valid_d.
  - No instruction is lost or duplicated across any stall length.
- Redirect (pc_src=1, overrides stall):
  - pc_q<=tgt, req_v<=1, pc_f<=tgt+4.
  - IF/ID <= bubble, which squashes the wrong-path instruction.
  - misalign_o<=(branch_target[1:0]!=0). Otherwise misalign_o<=0 every cycle.
- Redirect latency:
  - pc_src asserted in cycle N: the target instruction is visible on instr_d in cycle N+2, with valid_d=0 in cycle N+1.
  - Back-to-back pc_src: each redirect supersedes the previous; only the last target is fetched.
- Arithmetic:
  - All PC adds are modulo 2^DATA_WIDTH.
  - 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Scope: flushing ID/EX is not this block's responsibility.

Decomposition:
- Shared package (e.g. rv_pkg):
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_VECTOR.
  - Packed struct if_id_t {instr, pc, pc_plus4, valid}.
- One sub-module, if_id_reg: the IF/ID register with synchronous reset, hold (stall) and bubble-load (flush) controls, and flush priority over hold.
- PC/in-flight logic stays in fetch_unit.

Test Plan:
- Reset then free-run, RESET_VECTOR=0, imem word = address:
  - valid_d=0 for 1 cycle after reset release.
  - Then instr_d/pc_d = 0,4,8,… one per cycle, pc_plus4_d = pc_d+4.
- Stall during straight-line fetch: stall high 3 cycles while pc_d=8 -> instr_d/pc_d hold at 8, imem_addr=pc_q=C. After release, pc_d sequence is 8, C, 10 with no skip or repeat.
- Redirect: pc_src=1, branch_target=0x100 in cycle N while pc_d=0x10:
  - N+1: valid_d=0, instr_d=NOP.
  - N+2: pc_d=0x100.
  - N+3: pc_d=0x104.
- pc_src and stall high together, target 0x40 -> redirect wins; pc_d=0x40 two cycles later.
- Misaligned target 0x203:
  - imem_addr=0x200 in that cycle; misalign_o=1 for exactly one cycle.
  - Then pc_d=0x200.
- Wrap and reset mid-operation:
  - Redirect to 0xFFFF_FFFC -> pc_d sequence FFFF_FFFC, 0.
  - rst during a stall -> next fetch at RESET_VECTOR, valid_d=0, no stale instruction emitted.
